maze_player: RTL and testbench

MAZE_PLAYER -- requirements
Module: maze_player

---
 rtl/maze_pkg.sv | 29 ++
 rtl/move_cooldown.sv | 34 +++
 rtl/maze_player.sv | 157 +++++++++++++++
 tb/tb_maze_player.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze constants, direction encoding and player state enumeration
//   GRID_W/GRID_H : default maze dimensions in cells
//   dir_t         : move direction code, also used by the maze carver
//   state_t       : player FSM states
//   cell_index    : (x,y) -> bit position in the 256-bit cell bitmap
package maze_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2
    } state_t;

    // Bitmap row pitch is fixed at 16 cells regardless of GRID_W.
    function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/move_cooldown.sv
// rtl/move_cooldown.sv - post-move cooldown counter
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load count with load_val
//   load_val  : cooldown length in cycles
//   clear     : force count to zero (wins over load)
//   zero      : count is zero, a move may be evaluated
module move_cooldown #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/maze_player.sv
// rtl/maze_player.sv - button-driven player walking a snapshot of the carved maze
//   clk, rst            : clock, asynchronous active-high reset
//   maze_valid          : carver done; rising edge loads a maze, falling edge aborts to IDLE
//   maze_data           : cell bitmap, bit x+16*y, 1 = open
//   goal_x, goal_y      : finish cell
//   btn_up/left/down/right : single-cycle move requests, priority up > left > down > right
//   move_gap            : cooldown cycles after each accepted move
//   player_x, player_y  : current cell
//   move_count          : accepted moves since load, saturating at 1023
//   playing, won        : state PLAY / state WON
//   bump                : one-cycle pulse after a request rejected by a wall or the grid edge
module maze_player #(
    parameter int GRID_W = maze_pkg::GRID_W,
    parameter int GRID_H = maze_pkg::GRID_H
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         maze_valid,
    input  logic [255:0] maze_data,
    input  logic [3:0]   goal_x,
    input  logic [3:0]   goal_y,
    input  logic         btn_up,
    input  logic         btn_left,
    input  logic         btn_down,
    input  logic         btn_right,
    input  logic [25:0]  move_gap,
    output logic [3:0]   player_x,
    output logic [3:0]   player_y,
    output logic [9:0]   move_count,
    output logic         playing,
    output logic         won,
    output logic         bump
);

    import maze_pkg::*;

    localparam logic [4:0] W_LIM = 5'(GRID_W);
    localparam logic [4:0] H_LIM = 5'(GRID_H);

    state_t       state;
    logic         valid_q;
    logic [255:0] snap;
    logic [3:0]   goal_x_q;
    logic [3:0]   goal_y_q;

    logic         rise;
    logic         fall;
    logic         req_any;
    dir_t         dir;
    logic [4:0]   tx;
    logic [4:0]   ty;
    logic         in_range;
    logic         cell_open;
    logic         eval;
    logic         accept;
    logic         reject;
    logic         at_goal;
    logic         cd_zero;

    assign rise = maze_valid & ~valid_q;
    assign fall = ~maze_valid & valid_q;

    always_comb begin
        req_any = btn_up | btn_left | btn_down | btn_right;

        if (btn_up)        dir = DIR_UP;
        else if (btn_left) dir = DIR_LEFT;
        else if (btn_down) dir = DIR_DOWN;
        else               dir = DIR_RIGHT;

        // One extra bit so x-1 at x=0 becomes 31 and falls outside the grid.
        tx = {1'b0, player_x};
        ty = {1'b0, player_y};
        case (dir)
            DIR_UP:    ty = ty - 5'd1;
            DIR_LEFT:  tx = tx - 5'd1;
            DIR_DOWN:  ty = ty + 5'd1;
            DIR_RIGHT: tx = tx + 5'd1;
            default:   ;
        endcase

        in_range  = (tx < W_LIM) && (ty < H_LIM);
        cell_open = snap[cell_index(tx[3:0], ty[3:0])];
        at_goal   = (tx[3:0] == goal_x_q) && (ty[3:0] == goal_y_q);

        // Maze edges take precedence over buttons in the same cycle.
        eval   = (state == ST_PLAY) && cd_zero && req_any && !rise && !fall;
        accept = eval && in_range && cell_open;
        reject = eval && !(in_range && cell_open);
    end

    move_cooldown #(
        .WIDTH (26)
    ) u_cooldown (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (move_gap),
        .clear    (fall),
        .zero     (cd_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            valid_q    <= 1'b1;
            snap       <= '0;
            goal_x_q   <= '0;
            goal_y_q   <= '0;
            player_x   <= '0;
            player_y   <= '0;
            move_count <= '0;
            playing    <= 1'b0;
            won        <= 1'b0;
            bump       <= 1'b0;
        end else begin
            valid_q <= maze_valid;
            bump    <= reject;

            if (fall) begin
                state    <= ST_IDLE;
                playing  <= 1'b0;
                won      <= 1'b0;
                player_x <= '0;
                player_y <= '0;
            end else if (rise) begin
                snap       <= maze_data;
                goal_x_q   <= goal_x;
                goal_y_q   <= goal_y;
                player_x   <= '0;
                player_y   <= '0;
                move_count <= '0;
                if (goal_x == 4'd0 && goal_y == 4'd0) begin
                    state   <= ST_WON;
                    playing <= 1'b0;
                    won     <= 1'b1;
                end else begin
                    state   <= ST_PLAY;
                    playing <= 1'b1;
                    won     <= 1'b0;
                end
            end else if (accept) begin
                player_x <= tx[3:0];
                player_y <= ty[3:0];
                if (move_count != 10'd1023) begin
                    move_count <= move_count + 10'd1;
                end
                if (at_goal) begin
                    state   <= ST_WON;
                    playing <= 1'b0;
                    won     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_player.sv
// tb/tb_maze_player.sv - directed self-checking bench for maze_player
module tb_maze_player;

    logic         clk;
    logic         rst;
    logic         maze_valid;
    logic [255:0] maze_data;
    logic [3:0]   goal_x;
    logic [3:0]   goal_y;
    logic         btn_up;
    logic         btn_left;
    logic         btn_down;
    logic         btn_right;
    logic [25:0]  move_gap;
    logic [3:0]   player_x;
    logic [3:0]   player_y;
    logic [9:0]   move_count;
    logic         playing;
    logic         won;
    logic         bump;

    int errors = 0;
    int checks = 0;

    logic [255:0] maze_a;
    logic [255:0] maze_b;

    maze_player dut (
        .clk        (clk),
        .rst        (rst),
        .maze_valid (maze_valid),
        .maze_data  (maze_data),
        .goal_x     (goal_x),
        .goal_y     (goal_y),
        .btn_up     (btn_up),
        .btn_left   (btn_left),
        .btn_down   (btn_down),
        .btn_right  (btn_right),
        .move_gap   (move_gap),
        .player_x   (player_x),
        .player_y   (player_y),
        .move_count (move_count),
        .playing    (playing),
        .won        (won),
        .bump       (bump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic u, input logic l, input logic d, input logic r);
        btn_up = u; btn_left = l; btn_down = d; btn_right = r;
        tick();
        btn_up = 1'b0; btn_left = 1'b0; btn_down = 1'b0; btn_right = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input logic [9:0] cnt);
        chk({tag, ".x"}, 32'(player_x), 32'(x));
        chk({tag, ".y"}, 32'(player_y), 32'(y));
        chk({tag, ".count"}, 32'(move_count), 32'(cnt));
    endtask

    initial begin
        maze_a = '0;
        maze_a[0] = 1'b1; maze_a[1] = 1'b1; maze_a[17] = 1'b1;
        maze_b = '0;
        maze_b[0] = 1'b1; maze_b[1] = 1'b1; maze_b[17] = 1'b1;
        maze_b[18] = 1'b1; maze_b[19] = 1'b1; maze_b[35] = 1'b1;

        rst = 1'b1; maze_valid = 1'b1; maze_data = '0; goal_x = 4'd0; goal_y = 4'd0;
        btn_up = 1'b0; btn_left = 1'b0; btn_down = 1'b0; btn_right = 1'b0;
        move_gap = 26'd0;
        #1;
        chk_pos("reset", 4'd0, 4'd0, 10'd0);
        chk("reset.playing", 32'(playing), 32'd0);
        chk("reset.won", 32'(won), 32'd0);
        chk("reset.bump", 32'(bump), 32'd0);

        // maze_valid high through reset release must not look like a rising edge
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk("no_rise_after_reset.playing", 32'(playing), 32'd0);

        // load maze A, goal (1,1), no cooldown
        maze_valid = 1'b0;
        tick();
        maze_data = maze_a; goal_x = 4'd1; goal_y = 4'd1; maze_valid = 1'b1;
        tick();
        chk("load_a.playing", 32'(playing), 32'd1);
        chk_pos("load_a", 4'd0, 4'd0, 10'd0);
        maze_data = '1;   // snapshot must be used from here on

        // top and left edges
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("edge_up.bump", 32'(bump), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("edge_left.bump", 32'(bump), 32'd1);
        chk_pos("edges", 4'd0, 4'd0, 10'd0);
        tick();
        chk("bump_one_cycle", 32'(bump), 32'd0);

        // (0,1) is a wall in the snapshot although live maze_data is all open
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("snapshot_wall.bump", 32'(bump), 32'd1);
        chk_pos("snapshot_wall", 4'd0, 4'd0, 10'd0);

        // right then down reaches goal
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk_pos("move_right", 4'd1, 4'd0, 10'd1);
        chk("move_right.bump", 32'(bump), 32'd0);
        chk("move_right.won", 32'(won), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_pos("move_down_goal", 4'd1, 4'd1, 10'd2);
        chk("goal.won", 32'(won), 32'd1);
        chk("goal.playing", 32'(playing), 32'd0);

        // WON ignores buttons
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_pos("won_hold", 4'd1, 4'd1, 10'd2);
        chk("won_hold.bump", 32'(bump), 32'd0);

        // falling edge: IDLE, position reset, count held
        maze_valid = 1'b0;
        tick();
        chk("fall.playing", 32'(playing), 32'd0);
        chk("fall.won", 32'(won), 32'd0);
        chk_pos("fall", 4'd0, 4'd0, 10'd2);

        // rising edge with maze B; a same-cycle button is dropped
        maze_data = maze_b; goal_x = 4'd15; goal_y = 4'd15; maze_valid = 1'b1;
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        chk("load_b.playing", 32'(playing), 32'd1);
        chk_pos("load_b", 4'd0, 4'd0, 10'd0);
        chk("load_b.bump", 32'(bump), 32'd0);

        // up wins priority over right at the top edge
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("priority.bump", 32'(bump), 32'd1);
        chk_pos("priority", 4'd0, 4'd0, 10'd0);

        // cooldown of 5 cycles
        move_gap = 26'd5;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk_pos("cd_right", 4'd1, 4'd0, 10'd1);
        tick();
        tick();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_pos("cd_drop", 4'd1, 4'd0, 10'd1);
        chk("cd_drop.bump", 32'(bump), 32'd0);
        tick();
        tick();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_pos("cd_accept", 4'd1, 4'd1, 10'd2);

        // back-to-back moves with zero gap, last one leaves a long cooldown
        move_gap = 26'd0;
        repeat (5) tick();
        btn_right = 1'b1;
        tick();
        chk_pos("gap0_a", 4'd2, 4'd1, 10'd3);
        tick();
        chk_pos("gap0_b", 4'd3, 4'd1, 10'd4);
        btn_right = 1'b0;
        move_gap = 26'd100;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_pos("to_3_2", 4'd3, 4'd2, 10'd5);
        tick();
        tick();

        // asynchronous reset during cooldown
        #2 rst = 1'b1;
        #1;
        chk_pos("async_rst", 4'd0, 4'd0, 10'd0);
        chk("async_rst.playing", 32'(playing), 32'd0);
        chk("async_rst.won", 32'(won), 32'd0);
        chk("async_rst.bump", 32'(bump), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // move_count saturation, goal unreachable
        maze_valid = 1'b0;
        tick();
        maze_data = maze_a; goal_x = 4'd15; goal_y = 4'd15; move_gap = 26'd0;
        maze_valid = 1'b1;
        tick();
        chk("sat_load.playing", 32'(playing), 32'd1);
        for (int i = 0; i < 1030; i++) begin
            btn_right = (i % 2 == 0);
            btn_left  = (i % 2 == 1);
            tick();
        end
        btn_right = 1'b0; btn_left = 1'b0;
        tick();
        chk("saturate.count", 32'(move_count), 32'd1023);
        chk("saturate.x", 32'(player_x), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
